// File: rtl/ica_pkg.sv
// Shared ICA definitions: default matrix geometry, sample/frame types and
// the per-bank fill/hold state used by the frame loader.
package ica_pkg;

    localparam int DW = 32;
    localparam int N  = 64;
    localparam int CH = 3;

    typedef logic signed [DW-1:0]     sample_t;
    typedef sample_t [0:CH-1][0:N-1]  frame_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } bank_state_t;

endpackage

// File: rtl/u_frame_loader_if.sv
// Sample-stream and frame-presentation handshake between the source/consumer
// side (master) and the frame loader (slave).
interface u_frame_loader_if
    import ica_pkg::*;
#(
    parameter int DW = ica_pkg::DW,
    parameter int N  = ica_pkg::N,
    parameter int CH = ica_pkg::CH
);
    typedef logic signed [DW-1:0] smp_t;

    logic                      in_valid;
    logic                      in_ready;
    smp_t [0:CH-1]             in_x;
    logic                      frame_valid;
    logic                      frame_ack;
    smp_t [0:CH-1][0:N-1]      u;
    logic [15:0]               frame_count;

    modport master (
        output in_valid, in_x, frame_ack,
        input  in_ready, frame_valid, u, frame_count
    );

    modport slave (
        input  in_valid, in_x, frame_ack,
        output in_ready, frame_valid, u, frame_count
    );
endinterface

// File: rtl/u_frame_loader_bank.sv
// ufl_bank: one CH x N register bank; a write stores a full CH-wide sample
// into column i_addr, and the whole matrix is always visible on o_data.
module ufl_bank
    import ica_pkg::*;
#(
    parameter int DW = ica_pkg::DW,
    parameter int N  = ica_pkg::N,
    parameter int CH = ica_pkg::CH,
    localparam int AW = $clog2(N)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_we,
    input  logic [AW-1:0]                      i_addr,
    input  logic [0:CH-1][DW-1:0]              i_wdata,
    output logic [0:CH-1][0:N-1][DW-1:0]       o_data
);

    for (genvar gi = 0; gi < N; gi++) begin : g_col
        logic w_hit;
        assign w_hit = i_we && (i_addr == AW'(gi));

        for (genvar gc = 0; gc < CH; gc++) begin : g_chan
            logic [DW-1:0] r_cell;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cell <= '0;
                end else if (w_hit) begin
                    r_cell <= i_wdata[gc];
                end
            end

            assign o_data[gc][gi] = r_cell;
        end
    end

endmodule

// File: rtl/u_frame_loader.sv
// Streaming CH x N frame assembler with frame_valid/frame_ack presentation.
// Define UFL_PINGPONG_EN for two banks (fill one while the other is held).
module u_frame_loader
    import ica_pkg::*;
#(
    parameter int DW = ica_pkg::DW,
    parameter int N  = ica_pkg::N,
    parameter int CH = ica_pkg::CH
) (
    input  logic             clk,
    input  logic             rst,
    u_frame_loader_if.slave  bus
);

`ifdef UFL_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif
    localparam int AW = $clog2(N);

    bank_state_t                     r_state      [NB];
    bank_state_t                     w_state_next [NB];
    logic [AW-1:0]                   r_idx, w_idx_next;
    logic [15:0]                     r_frame_count, w_frame_count_next;
    logic [NB-1:0]                   w_hold;
    logic [NB-1:0]                   w_wr_sel, w_rd_sel;
    logic                            w_wr_hold, w_rd_hold;
    logic                            w_accept, w_complete, w_release;
    logic [0:CH-1][0:N-1][DW-1:0]    w_bank_data [NB];

    for (genvar gi = 0; gi < NB; gi++) begin : g_bank
        assign w_hold[gi] = (r_state[gi] == HOLD);

        ufl_bank #(.DW(DW), .N(N), .CH(CH)) u_bank (
            .clk     (clk),
            .rst     (rst),
            .i_we    (w_accept && w_wr_sel[gi]),
            .i_addr  (r_idx),
            .i_wdata (bus.in_x),
            .o_data  (w_bank_data[gi])
        );
    end

    // Bank pointers only exist with two banks; a single bank is always selected.
    if (NB == 2) begin : g_pingpong
        logic r_wb, r_rb;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_wb <= 1'b0;
                r_rb <= 1'b0;
            end else begin
                if (w_complete) r_wb <= ~r_wb;
                if (w_release)  r_rb <= ~r_rb;
            end
        end

        assign w_wr_sel = r_wb ? 2'b10 : 2'b01;
        assign w_rd_sel = r_rb ? 2'b10 : 2'b01;
        assign bus.u    = r_rb ? w_bank_data[1] : w_bank_data[0];
    end else begin : g_single
        assign w_wr_sel = 1'b1;
        assign w_rd_sel = 1'b1;
        assign bus.u    = w_bank_data[0];
    end

    assign w_wr_hold = |(w_hold & w_wr_sel);
    assign w_rd_hold = |(w_hold & w_rd_sel);

    assign bus.in_ready    = !w_wr_hold && !rst;
    assign bus.frame_valid = w_rd_hold;
    assign bus.frame_count = r_frame_count;

    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_complete = w_accept && (r_idx == AW'(N - 1));
    assign w_release  = bus.frame_ack && w_rd_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) r_state[b] <= FILL;
            r_idx         <= '0;
            r_frame_count <= '0;
        end else begin
            for (int b = 0; b < NB; b++) r_state[b] <= w_state_next[b];
            r_idx         <= w_idx_next;
            r_frame_count <= w_frame_count_next;
        end
    end

    // Release is applied before completion so a same-bank collision keeps HOLD.
    always_comb begin
        w_idx_next         = r_idx;
        w_frame_count_next = r_frame_count;
        for (int b = 0; b < NB; b++) w_state_next[b] = r_state[b];

        if (w_accept) begin
            w_idx_next = r_idx + 1'b1;
        end
        if (w_complete) begin
            w_frame_count_next = r_frame_count + 16'd1;
        end
        for (int b = 0; b < NB; b++) begin
            if (w_release && w_rd_sel[b])  w_state_next[b] = FILL;
            if (w_complete && w_wr_sel[b]) w_state_next[b] = HOLD;
        end
    end

endmodule

// File: tb/tb_u_frame_loader.sv
// Directed bench for u_frame_loader; the UFL_PINGPONG_EN build selects the
// two-bank scenarios, the default build the single-bank ones.
module tb_u_frame_loader;
    import ica_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_stall  = 0;

    u_frame_loader_if bus ();

    u_frame_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic signed [63:0] got,
                            input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic sample_t u_at(input int c, input int k);
        return sample_t'(bus.u[c][k]);
    endfunction

    // Called on a falling edge; returns on the falling edge after the accept.
    task automatic push(input sample_t a, input sample_t b, input sample_t c);
        int t = 0;
        bus.in_valid = 1'b1;
        bus.in_x[0]  = a;
        bus.in_x[1]  = b;
        bus.in_x[2]  = c;
        while (!bus.in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check_eq("push_timeout", t, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic ack();
        bus.frame_ack = 1'b1;
        @(negedge clk);
        bus.frame_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_frame_valid", bus.frame_valid, 0);
        check_eq("rst_frame_count", bus.frame_count, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_in_ready", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.frame_ack = 1'b0;
        bus.in_x      = '0;
        @(negedge clk);
        do_reset();
        check_eq("rst_u_0_0", u_at(0, 0), 0);
        check_eq("rst_u_2_63", u_at(2, 63), 0);

        // Frame of {k, -k, 2k}
        for (int k = 0; k < 64; k++) begin
            push(sample_t'(k), sample_t'(-k), sample_t'(2 * k));
            if (k == 62) check_eq("fv_before_last", bus.frame_valid, 0);
        end
        check_eq("fv_after_64", bus.frame_valid, 1);
        check_eq("u_0_5", u_at(0, 5), 5);
        check_eq("u_1_5", u_at(1, 5), -5);
        check_eq("u_2_63", u_at(2, 63), 126);
        check_eq("u_1_63", u_at(1, 63), -63);
        check_eq("frame_count_1", bus.frame_count, 1);

`ifndef UFL_PINGPONG_EN
        begin : single_bank_tests
            int n_rdy = 0;
            int n_chg = 0;
            check_eq("in_ready_full", bus.in_ready, 0);

            // Source stalls against a held frame for 100 cycles
            bus.in_valid = 1'b1;
            bus.in_x[0]  = sample_t'(999);
            bus.in_x[1]  = sample_t'(999);
            bus.in_x[2]  = sample_t'(999);
            repeat (100) begin
                @(negedge clk);
                if (bus.in_ready) n_rdy++;
                if (u_at(0, 63) != 63 || u_at(1, 5) != -5) n_chg++;
            end
            check_eq("stall_ready_cycles", n_rdy, 0);
            check_eq("stall_u_changes", n_chg, 0);
            check_eq("stall_fv", bus.frame_valid, 1);
            bus.in_valid = 1'b0;
            ack();
            check_eq("ack_fv", bus.frame_valid, 0);
            check_eq("ack_in_ready", bus.in_ready, 1);
            check_eq("ack_frame_count", bus.frame_count, 1);

            // Extremes with idle cycles carrying garbage data
            for (int k = 0; k < 64; k++) begin
                sample_t a;
                a = (k % 2 == 1) ? sample_t'(32'h8000_0000) : sample_t'(32'h7FFF_FFFF);
                push(a, ~a, sample_t'(k));
                bus.in_x[0] = sample_t'(555);
                bus.in_x[1] = sample_t'(-555);
                bus.in_x[2] = sample_t'(555);
                @(negedge clk);
            end
            check_eq("ext_fv", bus.frame_valid, 1);
            check_eq("ext_frame_count", bus.frame_count, 2);
            check_eq("ext_u_0_0", u_at(0, 0), sample_t'(32'h7FFF_FFFF));
            check_eq("ext_u_1_0", u_at(1, 0), sample_t'(32'h8000_0000));
            check_eq("ext_u_0_1", u_at(0, 1), sample_t'(32'h8000_0000));
            check_eq("ext_u_1_63", u_at(1, 63), sample_t'(32'h7FFF_FFFF));
            check_eq("ext_u_2_31", u_at(2, 31), 31);
            check_eq("ext_u_2_63", u_at(2, 63), 63);
            ack();

            // Reset after 30 samples of a new frame
            for (int k = 0; k < 30; k++) push(sample_t'(1000 + k), sample_t'(k), sample_t'(k));
            rst = 1'b1;
            @(negedge clk);
            check_eq("mid_rst_in_ready", bus.in_ready, 0);
            check_eq("mid_rst_fv", bus.frame_valid, 0);
            check_eq("mid_rst_u_0_0", u_at(0, 0), 0);
            check_eq("mid_rst_u_0_29", u_at(0, 29), 0);
            check_eq("mid_rst_frame_count", bus.frame_count, 0);
            rst = 1'b0;
            @(negedge clk);
            for (int k = 0; k < 64; k++) begin
                push(sample_t'(k + 7), sample_t'(-(k + 7)), sample_t'(3 * k));
                if (k == 62) check_eq("re_fv_before_last", bus.frame_valid, 0);
            end
            check_eq("re_fv", bus.frame_valid, 1);
            check_eq("re_u_0_0", u_at(0, 0), 7);
            check_eq("re_u_0_63", u_at(0, 63), 70);
            check_eq("re_u_1_0", u_at(1, 0), -7);
            check_eq("re_u_2_40", u_at(2, 40), 120);
            check_eq("re_frame_count", bus.frame_count, 1);
        end
`else
        begin : pingpong_tests
            check_eq("pp_in_ready_after_1st", bus.in_ready, 1);
            ack();
            do_reset();

            // Continuous stream of 4 frames; consumer acks 10 cycles after each
            fork
                begin
                    for (int k = 0; k < 256; k++) begin
                        if (!bus.in_ready) n_stall++;
                        push(sample_t'(k), sample_t'(-k), sample_t'(2 * k));
                    end
                end
                begin
                    for (int f = 0; f < 4; f++) begin
                        int t = 0;
                        while (!bus.frame_valid && t < 1000) begin
                            @(negedge clk);
                            t++;
                        end
                        if (t >= 1000) check_eq("pp_wait_timeout", t, 0);
                        check_eq("pp_frame_start", u_at(0, 0), f * 64);
                        check_eq("pp_frame_end", u_at(2, 63), 2 * (f * 64 + 63));
                        repeat (10) @(negedge clk);
                        ack();
                    end
                end
            join
            check_eq("pp_stall_cycles", n_stall, 0);
            check_eq("pp_frame_count", bus.frame_count, 4);
            check_eq("pp_fv_drained", bus.frame_valid, 0);

            // Two frames with no ack
            do_reset();
            for (int k = 0; k < 128; k++) push(sample_t'(k), sample_t'(k), sample_t'(k));
            check_eq("pp2_in_ready", bus.in_ready, 0);
            check_eq("pp2_fv", bus.frame_valid, 1);
            check_eq("pp2_u_0_0", u_at(0, 0), 0);
            check_eq("pp2_frame_count", bus.frame_count, 2);
            ack();
            check_eq("pp2_ack_fv", bus.frame_valid, 1);
            check_eq("pp2_ack_u_0_0", u_at(0, 0), 64);
            check_eq("pp2_ack_u_0_63", u_at(0, 63), 127);
            check_eq("pp2_ack_in_ready", bus.in_ready, 1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
